// File: rtl/xorexpand_stream_ctrl.sv
// xorexpand_stream_ctrl: captures an RNDSIZE-bit seed, expands it into the
// N = RNDSIZE*(RNDSIZE-1)/2 pairwise XOR bits, and streams the expansion out as
// W = ceil(N/OUTW) words with a valid/ready handshake.
// Optional feature: define XOREXPAND_ABORT_EN to add an abort input that drops
// the current seed and returns to IDLE.
module xorexpand_stream_ctrl #(
    parameter int unsigned RNDSIZE = 8,
    parameter int unsigned OUTW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_valid,
    input  logic [RNDSIZE-1:0] seed,
    output logic               seed_ready,
    output logic               out_valid,
    output logic [OUTW-1:0]    out_data,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy
`ifdef XOREXPAND_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam int unsigned N  = RNDSIZE * (RNDSIZE - 1) / 2;
    localparam int unsigned W  = (N + OUTW - 1) / OUTW;
    localparam int unsigned IW = $clog2(W + 1);
    localparam int unsigned PW = W * OUTW;
    localparam logic [IW-1:0] LastIdx = IW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StStream
    } state_e;

    state_e            state_q;
    logic [RNDSIZE-1:0] seed_q;
    logic [N-1:0]      buf_q;
    logic [IW-1:0]     idx_q;
    logic              abort_req;
    logic [PW-1:0]     pad;
    logic [PW-1:0]     shifted;

`ifdef XOREXPAND_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Pairs (i<j) are visited in increasing k order, so shifting each bit in at
    // the top leaves pair k at bit k after all N shifts.
    function automatic logic [N-1:0] expand(input logic [RNDSIZE-1:0] r);
        logic [N-1:0] p;
        p = '0;
        for (int i = 0; i < int'(RNDSIZE); i++) begin
            for (int j = i + 1; j < int'(RNDSIZE); j++) begin
                p        = p >> 1;
                p[N-1]   = r[i] ^ r[j];
            end
        end
        return p;
    endfunction

    // Control FSM: seed capture, one-cycle expansion, word streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            seed_q  <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (seed_valid) begin
                        seed_q  <= seed;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    idx_q <= '0;
                    if (abort_req) begin
                        state_q <= StIdle;
                    end else begin
                        buf_q   <= expand(seed_q);
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    // Abort beats a simultaneous final transfer.
                    if (abort_req) begin
                        idx_q   <= '0;
                        state_q <= StIdle;
                    end else if (out_ready) begin
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode from flops; seed_ready is also masked by rst so it stays
    // low for the whole time reset is held.
    always_comb begin
        pad         = '0;
        pad[N-1:0]  = buf_q;
        shifted     = pad >> (int'(idx_q) * int'(OUTW));
        out_valid   = (state_q == StStream);
        out_data    = out_valid ? shifted[OUTW-1:0] : '0;
        out_last    = out_valid && (idx_q == LastIdx);
        seed_ready  = (state_q == StIdle) && !rst;
        busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_xorexpand_stream_ctrl.sv
// Bench for xorexpand_stream_ctrl with RNDSIZE=4, OUTW=4 (N=6, W=2).
// Directed cases followed by random seeds and random backpressure, checked
// against a pairwise-XOR model built straight from the index formula.
module tb_xorexpand_stream_ctrl;

    localparam int R  = 4;
    localparam int OW = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          seed_valid;
    logic [R-1:0]  seed;
    logic          seed_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy;
`ifdef XOREXPAND_ABORT_EN
    logic          abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    xorexpand_stream_ctrl #(
        .RNDSIZE(R),
        .OUTW   (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_valid(seed_valid),
        .seed      (seed),
        .seed_ready(seed_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef XOREXPAND_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    // Word w of the expansion of r, bit k = r[i]^r[j], k = i*R - i*(i+1)/2 + j-i-1.
    function automatic logic [OW-1:0] exp_word(input logic [R-1:0] r, input int w);
        logic [15:0] pv;
        int k;
        pv = '0;
        for (int i = 0; i < R; i++) begin
            for (int j = i + 1; j < R; j++) begin
                k  = i * R - i * (i + 1) / 2 + j - i - 1;
                pv = pv | (16'(r[i] ^ r[j]) << k);
            end
        end
        return OW'(pv >> (OW * w));
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [OW-1:0] obs,
                            input logic [OW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer seed s, then consume all words; stall_pct sets random backpressure,
    // and during stalls a decoy seed is offered that must be ignored.
    task automatic run_seed(input logic [R-1:0] s, input int stall_pct);
        int w;
        int guard;
        logic rdy;
        guard = 0;
        while (!seed_ready && guard < 10) begin
            step();
            guard++;
        end
        chk_bit("seed_ready_before_offer", seed_ready, 1'b1);
        seed_valid = 1'b1;
        seed       = s;
        out_ready  = 1'b0;
        step();
        seed_valid = 1'b0;
        chk_bit("expand_out_valid", out_valid, 1'b0);
        chk_bit("expand_busy", busy, 1'b1);
        chk_bit("expand_seed_ready", seed_ready, 1'b0);
        step();
        w = 0;
        guard = 0;
        while (w < NW && guard < 200) begin
            chk_bit("stream_valid", out_valid, 1'b1);
            chk_word("stream_data", out_data, exp_word(s, w));
            chk_bit("stream_last", out_last, w == NW - 1);
            chk_bit("stream_seed_ready", seed_ready, 1'b0);
            rdy        = ($urandom_range(99) >= stall_pct);
            out_ready  = rdy;
            seed_valid = !rdy;
            seed       = ~s;
            step();
            if (rdy) w++;
            guard++;
        end
        chk_bit("stream_completed_in_budget", guard < 200, 1'b1);
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        chk_bit("after_last_valid", out_valid, 1'b0);
        chk_bit("after_last_busy", busy, 1'b0);
        chk_bit("after_last_seed_ready", seed_ready, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed       = '0;
        out_ready  = 1'b0;
        step();
        step();
        chk_bit("rst_seed_ready_low", seed_ready, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_out_last", out_last, 1'b0);
        chk_word("rst_out_data", out_data, 4'h0);
        chk_bit("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        chk_bit("post_rst_seed_ready", seed_ready, 1'b1);

        // Known vectors, full speed.
        chk_word("model_0001_w0", exp_word(4'b0001, 0), 4'b0111);
        run_seed(4'b0001, 0);
        run_seed(4'b1010, 0);

        // Word 0 held for 3 stalled cycles with a decoy seed offered.
        seed_valid = 1'b1;
        seed       = 4'b1010;
        step();
        seed_valid = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            seed_valid = 1'b1;
            seed       = 4'b0110;
            chk_word("stall_hold_data", out_data, 4'b1101);
            chk_bit("stall_hold_last", out_last, 1'b0);
            chk_bit("stall_seed_ready", seed_ready, 1'b0);
            step();
        end
        seed_valid = 1'b0;
        out_ready  = 1'b1;
        chk_word("stall_release_w0", out_data, 4'b1101);
        step();
        chk_word("stall_w1", out_data, 4'b0010);
        chk_bit("stall_w1_last", out_last, 1'b1);
        step();
        out_ready = 1'b0;
        chk_bit("stall_done_idle", busy, 1'b0);

        // Back-to-back seeds with seed_valid held high.
        seed_valid = 1'b1;
        seed       = 4'b0001;
        out_ready  = 1'b1;
        step();
        seed = 4'b1010;
        step();
        chk_word("b2b_w0", out_data, 4'b0111);
        step();
        chk_word("b2b_w1", out_data, 4'b0000);
        chk_bit("b2b_w1_last", out_last, 1'b1);
        step();
        chk_bit("b2b_second_ready", seed_ready, 1'b1);
        chk_bit("b2b_gap_valid", out_valid, 1'b0);
        step();
        seed_valid = 1'b0;
        chk_bit("b2b_second_expand", busy, 1'b1);
        step();
        chk_word("b2b_w2", out_data, 4'b1101);
        step();
        chk_word("b2b_w3", out_data, 4'b0010);
        step();
        out_ready = 1'b0;
        chk_bit("b2b_done", out_valid, 1'b0);

        // Reset while word 1 is pending.
        seed_valid = 1'b1;
        seed       = 4'b1010;
        step();
        seed_valid = 1'b0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_word("rst_mid_w1_pending", out_data, 4'b0010);
        rst = 1'b1;
        step();
        chk_bit("rst_mid_valid", out_valid, 1'b0);
        chk_bit("rst_mid_busy", busy, 1'b0);
        chk_bit("rst_mid_seed_ready", seed_ready, 1'b0);
        rst = 1'b0;
        #1;
        run_seed(4'b0001, 0);

`ifdef XOREXPAND_ABORT_EN
        // Abort during word 0.
        seed_valid = 1'b1;
        seed       = 4'b1010;
        step();
        seed_valid = 1'b0;
        step();
        chk_word("abort_w0", out_data, 4'b1101);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_bit("abort_valid", out_valid, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        step();
        chk_bit("abort_no_w1", out_valid, 1'b0);
        run_seed(4'b0001, 0);
`endif

        // Random seeds with random backpressure.
        for (int n = 0; n < 20; n++) begin
            run_seed(R'($urandom), 40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xorexpand_stream_ctrl.md
XOREXPAND_STREAM_CTRL -- requirements
Module: xorexpand_stream_ctrl

Interface
REQ-001 SHALL have parameter RNDSIZE, default 8: seed width in bits; legal range 2..64.
REQ-002 SHALL have parameter OUTW, default 8: output word width in bits; legal range 1..N.
REQ-003 SHALL define N = RNDSIZE*(RNDSIZE-1)/2 as the expanded bit count and W = ceil(N/OUTW) as the words per seed.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port seed_valid, input, 1 bit: a seed is offered.
REQ-007 SHALL have port seed, input, RNDSIZE bits: the seed value r.
REQ-008 SHALL have port seed_ready, output, 1 bit: the block accepts a seed.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_data, output, OUTW bits: the current expanded word.
REQ-011 SHALL have port out_last, output, 1 bit: the current word is word W-1.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL compute expanded bit p[k] = r[i] XOR r[j] for every pair i<j, with k = i*RNDSIZE - i*(i+1)/2 + j - i - 1.
REQ-015 SHALL implement FSM states IDLE, EXPAND and STREAM.
REQ-016 In IDLE: seed_ready=1; on seed_valid&&seed_ready, SHALL capture seed into a seed register and go to EXPAND.
REQ-017 In EXPAND (exactly one cycle): SHALL register all N p bits into an expansion buffer, clear the word index to 0, and go to STREAM.
REQ-018 In STREAM: out_valid=1; out_data = buffer bits [idx*OUTW +: OUTW], with bits at positions >= N driven 0 (last-word zero padding).
REQ-019 out_last SHALL equal (idx == W-1) while out_valid=1, and SHALL be 0 otherwise.
REQ-020 On out_valid&&out_ready with idx<W-1, SHALL increment idx; with idx==W-1, SHALL go to IDLE.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_last and idx SHALL hold stable.
REQ-022 Latency: seed accepted at edge T SHALL give out_valid=1 after edge T+1, i.e. word 0 presented in the second cycle after acceptance.
REQ-023 Throughput: one word per cycle with out_ready held high; a new seed is accepted no earlier than the cycle after the last-word transfer.
REQ-024 seed_ready SHALL be 0 in EXPAND and STREAM; seed_valid in those states SHALL be ignored.
REQ-025 seed_ready and out_valid SHALL never be 1 in the same cycle.
REQ-026 idx SHALL be ceil(log2(W+1)) bits wide and SHALL never exceed W-1.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, idx=0, seed register=0 and buffer=0, from any state including mid-stream.
REQ-028 Reset output values SHALL be: seed_ready=1 in the cycle after reset releases, and seed_ready=0 while rst=1; out_valid=0; out_last=0; out_data=0; busy=0.
REQ-029 A word pending at reset SHALL be discarded and never re-presented.

Configuration
REQ-030 Macro XOREXPAND_ABORT_EN defined SHALL add input port abort (1 bit); abort=1 at an edge in EXPAND or STREAM SHALL return the FSM to IDLE with idx=0 and out_valid=0 next cycle; an abort arriving with a final transfer SHALL win; abort in IDLE SHALL have no effect; rst SHALL have priority over abort.
REQ-031 Macro XOREXPAND_ABORT_EN undefined SHALL leave no abort port, and each seed SHALL always stream all W words.

Verification (RNDSIZE=4, OUTW=4, so N=6, W=2)
REQ-032 Reset then seed=4'b0001 with out_ready=1 -> out_valid two cycles after acceptance; words 4'b0111 then 4'b0000; out_last on the second word; back in IDLE.
REQ-033 Seed=4'b1010 -> words 4'b1101 then 4'b0010 (upper two bits padded 0).
REQ-034 Seed=4'b1010 with out_ready low for 3 cycles on word 0 -> 4'b1101 held stable for 3 cycles; seed_valid asserted meanwhile is ignored (seed_ready=0).
REQ-035 Back-to-back seeds 4'b0001 then 4'b1010 with seed_valid held high -> second seed accepted the cycle after the first out_last transfer; 4 words total in order.
REQ-036 rst pulsed while word 1 is pending -> out_valid=0 and busy=0 next cycle; the next seed streams from word 0.
REQ-037 XOREXPAND_ABORT_EN defined: abort during word 0 of seed 4'b1010 -> out_valid=0 next cycle, state IDLE, no word 1 emitted.
